// File: rtl/dual_port_sync_ram.sv
// Dual-port synchronous RAM: port A read/write with byte-lane enables,
// port B read-only. Optional zero-fill of the whole array after reset,
// during which both ports are held off and busy is raised.
// Read latency of 1 or 2 cycles; valid travels with the read data.

`timescale 1ns/1ps

module dual_port_sync_ram #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int RD_LATENCY     = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_en,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_en,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid,
    output logic                    busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   fill_cnt;
    logic                    fill_last;
    logic                    fill_we;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    a_wr;
    logic                    a_rd;
    logic                    b_rd;

    logic                    a_vld_p1;
    logic                    b_vld_p1;
    logic [DATA_WIDTH-1:0]   a_rdata_p1;
    logic [DATA_WIDTH-1:0]   b_rdata_p1;

    // State register: reset lands in CLEAR only when zero-fill is enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR_ON_RESET ? CLEAR : READY;
        end else begin
            state <= state_nxt;
        end
    end

    assign fill_last = (fill_cnt == {ADDR_WIDTH{1'b1}});

    // Next-state logic: leave CLEAR once the last word has been zeroed
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (fill_last) state_nxt = READY;
            READY:   state_nxt = READY;
            default: state_nxt = state;
        endcase
    end

    // Output logic: busy reflects the reset target directly while rst is held
    always_comb begin
        busy    = 1'b0;
        fill_we = 1'b0;
        if (rst) begin
            busy = CLEAR_ON_RESET;
        end else begin
            busy    = (state == CLEAR);
            fill_we = (state == CLEAR);
        end
    end

    // Fill address counter; wraps to zero after the last word
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
        end else if (fill_we) begin
            fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
        end
    end

    // Request qualification: busy also covers the reset cycle
    assign a_wr = a_en &  a_we & ~busy;
    assign a_rd = a_en & ~a_we & ~busy;
    assign b_rd = b_en & ~busy;

    // Array write: zero-fill has the port while busy, otherwise port A byte lanes
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[fill_cnt] <= '0;
        end else if (a_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (a_be[i]) begin
                    mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
                end
            end
        end
    end

    // ---- stage p1: array read (old data on a same-edge write) ----
    // Port A read register; data only moves on an accepted read
    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_p1   <= 1'b0;
            a_rdata_p1 <= '0;
        end else begin
            a_vld_p1 <= a_rd;
            if (a_rd) begin
                a_rdata_p1 <= mem[a_addr];
            end
        end
    end

    // Port B read register; data only moves on an accepted read
    always_ff @(posedge clk) begin
        if (rst) begin
            b_vld_p1   <= 1'b0;
            b_rdata_p1 <= '0;
        end else begin
            b_vld_p1 <= b_rd;
            if (b_rd) begin
                b_rdata_p1 <= mem[b_addr];
            end
        end
    end

    // ---- stage p2: optional output register ----
    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  a_vld_p2;
            logic                  b_vld_p2;
            logic [DATA_WIDTH-1:0] a_rdata_p2;
            logic [DATA_WIDTH-1:0] b_rdata_p2;

            // Output register advances only behind a valid p1 word, so it holds otherwise
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_vld_p2   <= 1'b0;
                    b_vld_p2   <= 1'b0;
                    a_rdata_p2 <= '0;
                    b_rdata_p2 <= '0;
                end else begin
                    a_vld_p2 <= a_vld_p1;
                    b_vld_p2 <= b_vld_p1;
                    if (a_vld_p1) begin
                        a_rdata_p2 <= a_rdata_p1;
                    end
                    if (b_vld_p1) begin
                        b_rdata_p2 <= b_rdata_p1;
                    end
                end
            end

            assign a_rdata  = a_rdata_p2;
            assign a_rvalid = a_vld_p2;
            assign b_rdata  = b_rdata_p2;
            assign b_rvalid = b_vld_p2;
        end else begin : g_lat1
            assign a_rdata  = a_rdata_p1;
            assign a_rvalid = a_vld_p1;
            assign b_rdata  = b_rdata_p1;
            assign b_rvalid = b_vld_p1;
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_sync_ram.sv
// Bench for dual_port_sync_ram: two instances (read latency 1 and 2) share
// one stimulus stream; expected read words are queued with their due edge
// and compared when the matching rvalid should pulse.

`timescale 1ns/1ps

module tb_dual_port_sync_ram;

    logic        clk;
    logic        rst;
    logic        a_en;
    logic        a_we;
    logic [3:0]  a_be;
    logic [3:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_en;
    logic [3:0]  b_addr;

    logic [31:0] a_rdata1, b_rdata1, a_rdata2, b_rdata2;
    logic        a_rvalid1, b_rvalid1, a_rvalid2, b_rvalid2;
    logic        busy1, busy2;

    dual_port_sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
        .busy(busy1)
    );

    dual_port_sync_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(2), .CLEAR_ON_RESET(1'b1)) dut2 (
        .clk(clk), .rst(rst),
        .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata2), .a_rvalid(a_rvalid2),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata2), .b_rvalid(b_rvalid2),
        .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        a_en;
        logic        a_we;
        logic [3:0]  a_be;
        logic [3:0]  a_addr;
        logic [31:0] a_wdata;
        logic        b_en;
        logic [3:0]  b_addr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    logic [31:0] last_d[4];
    string       pname[4];
    int          edge_cnt;
    int          total;
    int          passed;
    logic        started;
    logic        rst_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h (edge %0d)", name, act, exp, edge_cnt);
    endtask

    task automatic check_port(input int p, input logic v, input logic [31:0] d);
        int j;
        j = -1;
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].port == p) begin
                j = k;
                break;
            end
        end
        if (j >= 0 && sb[j].due == edge_cnt) begin
            chk({pname[p], "_rvalid"}, {31'd0, v}, 32'd1);
            chk({pname[p], "_rdata"}, d, sb[j].data);
            last_d[p] = sb[j].data;
            sb.delete(j);
        end else begin
            chk({pname[p], "_rvalid_idle"}, {31'd0, v}, 32'd0);
            chk({pname[p], "_rdata_hold"}, d, last_d[p]);
        end
    endtask

    // Monitor: sample #1 after each edge; a reset edge drops every queued read
    always @(posedge clk) begin
        rst_s = rst;
        edge_cnt++;
        #1;
        if (rst_s) begin
            started = 1'b1;
            sb.delete();
            for (int p = 0; p < 4; p++) last_d[p] = 32'd0;
        end
        if (started) begin
            check_port(0, a_rvalid1, a_rdata1);
            check_port(1, b_rvalid1, b_rdata1);
            check_port(2, a_rvalid2, a_rdata2);
            check_port(3, b_rvalid2, b_rdata2);
        end
    end

    function automatic vec_t mk(input logic ae, input logic we, input logic [3:0] be,
                                input logic [3:0] aa, input logic [31:0] wd,
                                input logic bn, input logic [3:0] ba,
                                input logic [31:0] ea, input logic [31:0] eb);
        vec_t v;
        v.a_en = ae; v.a_we = we; v.a_be = be; v.a_addr = aa; v.a_wdata = wd;
        v.b_en = bn; v.b_addr = ba; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    // Apply one vector for one edge; acc=1 means the DUT is expected to accept reads
    task automatic step(input vec_t v, input bit acc);
        a_en = v.a_en; a_we = v.a_we; a_be = v.a_be; a_addr = v.a_addr;
        a_wdata = v.a_wdata; b_en = v.b_en; b_addr = v.b_addr;
        if (acc) begin
            if (v.a_en && !v.a_we) begin
                sb.push_back('{port: 0, data: v.exp_a, due: edge_cnt + 1});
                sb.push_back('{port: 2, data: v.exp_a, due: edge_cnt + 2});
            end
            if (v.b_en) begin
                sb.push_back('{port: 1, data: v.exp_b, due: edge_cnt + 1});
                sb.push_back('{port: 3, data: v.exp_b, due: edge_cnt + 2});
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(mk(0, 0, 4'h0, 4'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0), 1'b0);
    endtask

    // Count cycles with busy high (bounded); hammer both ports meanwhile
    task automatic busy_count(output int n1, output int n2);
        n1 = 0;
        n2 = 0;
        while (busy1 === 1'b1 && n1 < 64) begin
            n1++;
            if (busy2 === 1'b1) n2++;
            step(mk(1, n1[0], 4'hF, 4'h0, 32'hDEADBEEF, 1, 4'h0, 32'h0, 32'h0), 1'b0);
        end
        if (busy2 === 1'b1) n2 = n2 + 100;
        a_en = 0; a_we = 0; b_en = 0;
    endtask

    int n1, n2;

    initial begin
        pname[0] = "a_lat1"; pname[1] = "b_lat1"; pname[2] = "a_lat2"; pname[3] = "b_lat2";
        total = 0; passed = 0; edge_cnt = 0; started = 1'b0;
        for (int p = 0; p < 4; p++) last_d[p] = 32'd0;

        // Vector table: full-range zero check, byte lanes, collisions, B burst
        for (int i = 0; i < 16; i++)
            tbl.push_back(mk(1, 0, 4'h0, 4'(i), 32'h0, 1, 4'(15 - i), 32'h0, 32'h0));
        tbl.push_back(mk(1, 1, 4'hF, 4'd0, 32'h00000010, 0, 4'd0, 32'h0, 32'h0));
        tbl.push_back(mk(1, 1, 4'hF, 4'd1, 32'h00000021, 0, 4'd0, 32'h0, 32'h0));
        tbl.push_back(mk(1, 1, 4'hF, 4'd2, 32'h00000032, 0, 4'd0, 32'h0, 32'h0));
        tbl.push_back(mk(1, 1, 4'hF, 4'd3, 32'hAABBCCDD, 1, 4'd3, 32'h0, 32'h0));
        tbl.push_back(mk(1, 1, 4'h5, 4'd3, 32'h11223344, 1, 4'd3, 32'h0, 32'hAABBCCDD));
        tbl.push_back(mk(1, 0, 4'h0, 4'd3, 32'h0, 1, 4'd3, 32'hAA22CC44, 32'hAA22CC44));
        tbl.push_back(mk(1, 1, 4'h0, 4'd5, 32'hFFFFFFFF, 1, 4'd5, 32'h0, 32'h0));
        tbl.push_back(mk(1, 0, 4'hF, 4'd5, 32'h0, 0, 4'd0, 32'h0, 32'h0));
        tbl.push_back(mk(1, 1, 4'hF, 4'd7, 32'h00000009, 0, 4'd0, 32'h0, 32'h0));
        tbl.push_back(mk(1, 1, 4'hF, 4'd7, 32'h00000005, 1, 4'd7, 32'h0, 32'h00000009));
        tbl.push_back(mk(1, 0, 4'h0, 4'd7, 32'h0, 1, 4'd7, 32'h00000005, 32'h00000005));
        tbl.push_back(mk(1, 1, 4'h8, 4'd9, 32'hA5A5A5A5, 1, 4'd9, 32'h0, 32'h0));
        tbl.push_back(mk(1, 1, 4'h2, 4'd9, 32'h77773C77, 1, 4'd9, 32'h0, 32'hA5000000));
        tbl.push_back(mk(1, 0, 4'h0, 4'd9, 32'h0, 1, 4'd0, 32'hA5003C00, 32'h00000010));
        tbl.push_back(mk(1, 0, 4'h0, 4'd7, 32'h0, 1, 4'd1, 32'h00000005, 32'h00000021));
        tbl.push_back(mk(1, 0, 4'h0, 4'd5, 32'h0, 1, 4'd2, 32'h00000000, 32'h00000032));
        tbl.push_back(mk(1, 0, 4'h0, 4'd3, 32'h0, 1, 4'd3, 32'hAA22CC44, 32'hAA22CC44));

        // Reset and first fill, with requests issued while busy
        rst = 1'b1;
        a_en = 0; a_we = 0; a_be = 4'h0; a_addr = 4'h0; a_wdata = 32'h0; b_en = 0; b_addr = 4'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("busy_in_rst_lat1", {31'd0, busy1}, 32'd1);
        chk("busy_in_rst_lat2", {31'd0, busy2}, 32'd1);
        rst = 1'b0;
        busy_count(n1, n2);
        chk("fill_len_lat1", n1, 32'd16);
        chk("fill_len_lat2", n2, 32'd16);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);
        idle(3);

        // Reset with a read in flight on the latency-2 instance
        step(mk(1, 0, 4'h0, 4'd3, 32'h0, 1, 4'd2, 32'hAA22CC44, 32'h00000032), 1'b1);
        rst = 1'b1;
        idle(1);
        chk("busy_rst_inflight_lat1", {31'd0, busy1}, 32'd1);
        chk("busy_rst_inflight_lat2", {31'd0, busy2}, 32'd1);
        rst = 1'b0;

        // Reset again once five words have been filled: fill must restart at word 0
        idle(5);
        chk("busy_midfill_lat1", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        idle(1);
        chk("busy_rst_midfill_lat1", {31'd0, busy1}, 32'd1);
        chk("busy_rst_midfill_lat2", {31'd0, busy2}, 32'd1);
        rst = 1'b0;
        busy_count(n1, n2);
        chk("refill_len_lat1", n1, 32'd16);
        chk("refill_len_lat2", n2, 32'd16);

        for (int i = 0; i < 16; i++) step(tbl[i], 1'b1);
        idle(3);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dual_port_sync_ram.md
DUAL_PORT_SYNC_RAM -- requirements
Module: dual_port_sync_ram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word address width; depth DEPTH = 2^ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits; must be a multiple of 8.
REQ-003 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; 1 means zero-fill all words after reset, 0 means no fill.
REQ-005 SHALL derive local constant NB = DATA_WIDTH/8, the byte-lane count.
REQ-006 SHALL have ports:
  clk       in   1           single clock; all state changes on rising edge
  rst       in   1           synchronous, active-high reset
  a_en      in   1           port A request strobe
  a_we      in   1           port A write when 1, read when 0
  a_be      in   NB          port A byte-lane write enables
  a_addr    in   ADDR_WIDTH  port A word address
  a_wdata   in   DATA_WIDTH  port A write data
  a_rdata   out  DATA_WIDTH  port A read data
  a_rvalid  out  1           port A read data valid, one-cycle pulse per read
  b_en      in   1           port B read request strobe (B is read-only)
  b_addr    in   ADDR_WIDTH  port B word address
  b_rdata   out  DATA_WIDTH  port B read data
  b_rvalid  out  1           port B read data valid, one-cycle pulse per read
  busy      out  1           high while zero-fill runs; requests ignored

Function
REQ-007 SHALL implement a two-state FSM: CLEAR, READY.
REQ-008 CLEAR: SHALL write zero to word fill_cnt each cycle; fill_cnt counts 0 to DEPTH-1; after the DEPTH-1 write, the next state is READY.
REQ-009 busy SHALL be 1 exactly in CLEAR; fill therefore takes DEPTH cycles after rst deasserts.
REQ-010 In CLEAR, a_en and b_en SHALL be ignored: no write, no rvalid.
REQ-011 Port A write (a_en & a_we & !busy at a rising edge) SHALL update only the byte lanes with a_be[i]=1; a_be=0 leaves the word unchanged; a write produces no a_rvalid.
REQ-012 Port A read (a_en & !a_we & !busy) at edge N SHALL drive a_rdata = mem[a_addr] with a_rvalid=1 during the cycle after edge N+RD_LATENCY-1 (i.e. visible after edge N+RD_LATENCY-1 settles); a_rvalid is a single-cycle pulse per read.
REQ-013 Port B reads SHALL follow REQ-012 identically, using b_en, b_addr, b_rdata, b_rvalid.
REQ-014 Both ports SHALL accept one request per cycle with no stalls; back-to-back reads return back-to-back rvalid pulses in issue order.
REQ-015 Same-address collision (A write and B read to one word at the same edge) SHALL return old data on B (read-before-write); the new data is visible to reads issued at a later edge.
REQ-016 a_rdata and b_rdata SHALL hold their last value while the matching rvalid is 0.
REQ-017 RD_LATENCY=2 SHALL add one output register stage after the array read; the valid pipeline is advanced in lockstep with the data.
REQ-018 Addresses SHALL cover the full 0..DEPTH-1 range; no out-of-range case exists.

Reset
REQ-019 While rst=1: a_rvalid=0, b_rvalid=0, a_rdata=0, b_rdata=0, fill_cnt=0, all in-flight reads dropped.
REQ-020 While rst=1: state=CLEAR and busy=1 if CLEAR_ON_RESET=1; state=READY and busy=0 otherwise.
REQ-021 Reset asserted mid-fill or mid-read SHALL restart fill from word 0 and emit no rvalid for reads issued before reset.
REQ-022 Memory contents SHALL NOT be reset directly; they change only by fill or by writes.

Verification
REQ-023 ADDR_WIDTH=4, CLEAR_ON_RESET=1, reset released -> busy high exactly 16 cycles; then reads of all 16 addresses return 0.
REQ-024 Write 0xAABBCCDD to addr 3 with a_be=4'b1111, then a_be=4'b0101 with data 0x11223344 -> a read of addr 3 returns 0xAA22CC44.
REQ-025 A writes 0x5 to addr 7 while B reads addr 7 at the same edge (old value 0x9) -> b_rdata=0x9; a B read one cycle later returns 0x5.
REQ-026 RD_LATENCY=2, four consecutive B reads of addrs 0..3 -> four contiguous b_rvalid pulses, first pulse two cycles after the first request, data in order.
REQ-027 rst asserted for 1 cycle with a read in flight and fill_cnt=5 -> no rvalid for that read; busy stays 1 and fill restarts at 0.
REQ-028 Requests issued while busy=1 -> no memory change and no rvalid.
